// File: rtl/field_select_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : field_select_pkg
//  Description : Shared types and helpers for the field_select_pipe slice:
//                skid-buffer state encoding and the field-offset helper.
//  Revision    : 1.0  initial parametrised, handshaked release
// ============================================================================
package field_select_pkg;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

  // Locates field `sel` in a packed word. `shift` is the bit offset of the
  // field's LSB; `err` flags a select index with no matching field, in which
  // case `shift` is zero and must not be used.
  function automatic void field_extract(
    input  int unsigned sel,
    input  int unsigned num_fields,
    input  int unsigned sel_w,
    input  int unsigned field_w,
    output int unsigned shift,
    output logic        err
  );
    err   = (sel >= num_fields);
    shift = err ? 0 : sel_w + sel * field_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/field_select_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : field_select_pipe_if
//  Description : Input word stream and selected-field output stream of
//                field_select_pipe. The block itself uses the slave modport,
//                the source/sink side uses master.
//  Revision    : 1.0  initial release
// ============================================================================
interface field_select_pipe_if #(
  parameter int DATA_W  = 16,
  parameter int FIELD_W = 3
);
  logic               i_valid;
  logic               o_ready;
  logic [DATA_W-1:0]  i_data;
  logic               o_valid;
  logic               i_ready;
  logic [FIELD_W-1:0] o_data;
  logic               o_err;

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_data, o_err
  );

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_data, o_err
  );
endinterface
`default_nettype wire

// File: rtl/field_select_skid.sv
`default_nettype none
// ============================================================================
//  Module      : field_select_skid
//  Description : Generic two-entry skid buffer. Main register M drives the
//                outputs, skid register S catches the word accepted while M
//                is still waiting. o_ready and o_valid are registers decoded
//                from the occupancy state, never combinational from i_ready.
//  Revision    : 1.0  initial release
// ============================================================================
module field_select_skid
  import field_select_pkg::*;
#(
  parameter type T = logic [3:0]
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  output logic o_valid,
  input  logic i_ready,
  output T     o_data
);

  buf_state_t r_state;
  T           r_main;
  T           r_skid;
  logic       r_valid;
  logic       r_ready;

  // Occupancy FSM: moves words through M/S and registers the handshake outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_EMPTY;
      r_valid <= 1'b0;
      r_ready <= 1'b1;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (i_valid) begin
            r_main  <= i_data;
            r_valid <= 1'b1;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (i_valid && i_ready) begin
            r_main <= i_data;
          end else if (i_valid) begin
            r_skid  <= i_data;
            r_ready <= 1'b0;
            r_state <= ST_TWO;
          end else if (i_ready) begin
            r_valid <= 1'b0;
            r_state <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          // o_ready is low here, so i_valid cannot be accepted.
          if (i_ready) begin
            r_main  <= r_skid;
            r_ready <= 1'b1;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
          r_valid <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_data  = r_main;

endmodule
`default_nettype wire

// File: rtl/field_select_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : field_select_pipe
//  Description : Extracts the field addressed by the low SEL_W bits of each
//                input word and delivers it on a valid/ready stream through a
//                two-entry skid buffer. An index with no matching field yields
//                data 0 with o_err set.
//                Optional macro FIELD_SELECT_CNT_EN adds o_xfer_cnt (good
//                transfers, wrapping) and o_err_cnt (errored transfers,
//                saturating).
//  Revision    : 1.0  initial parametrised, handshaked release
// ============================================================================
module field_select_pipe
  import field_select_pkg::*;
#(
  parameter int FIELD_W    = 3,
  parameter int NUM_FIELDS = 4,
  parameter int DATA_W     = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
`ifdef FIELD_SELECT_CNT_EN
  output logic [15:0]         o_xfer_cnt,
  output logic [7:0]          o_err_cnt,
`endif
  field_select_pipe_if.slave  bus
);

  localparam int SEL_W = $clog2(NUM_FIELDS);

  typedef struct packed {
    logic [FIELD_W-1:0] data;
    logic               err;
  } entry_t;

  generate
    if (NUM_FIELDS < 2 || DATA_W < SEL_W + NUM_FIELDS * FIELD_W) begin : g_param_check
      $error("field_select_pipe: NUM_FIELDS must be >= 2 and DATA_W >= SEL_W + NUM_FIELDS*FIELD_W");
    end
  endgenerate

  entry_t      w_in;
  entry_t      w_out;
  int unsigned w_shift;
  logic        w_err;

  // Field extraction from the incoming word; registered by the skid buffer.
  always_comb begin
    field_extract(32'(bus.i_data[SEL_W-1:0]), NUM_FIELDS, SEL_W, FIELD_W, w_shift, w_err);
    w_in.err  = w_err;
    w_in.data = w_err ? '0 : FIELD_W'(bus.i_data >> w_shift);
  end

  field_select_skid #(
    .T (entry_t)
  ) u_skid (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_valid (bus.i_valid),
    .o_ready (bus.o_ready),
    .i_data  (w_in),
    .o_valid (bus.o_valid),
    .i_ready (bus.i_ready),
    .o_data  (w_out)
  );

  assign bus.o_data = w_out.data;
  assign bus.o_err  = w_out.err;

`ifdef FIELD_SELECT_CNT_EN
  logic        w_xfer;
  logic [15:0] r_xfer_cnt;
  logic [7:0]  r_err_cnt;

  assign w_xfer = bus.o_valid & bus.i_ready;

  // Transfer statistics: good transfers wrap, errored transfers saturate.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_xfer_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (w_xfer) begin
      if (w_out.err) begin
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end else begin
        r_xfer_cnt <= r_xfer_cnt + 16'd1;
      end
    end
  end

  assign o_xfer_cnt = r_xfer_cnt;
  assign o_err_cnt  = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_field_select_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_field_select_pipe
//  Description : Self-checking bench for field_select_pipe. Instance A uses
//                the default configuration, instance B has NUM_FIELDS=3 /
//                DATA_W=11 so out-of-range selects are reachable. Directed
//                steps followed by random traffic against a FIFO reference.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_field_select_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  field_select_pipe_if #(.DATA_W(16), .FIELD_W(3)) bus_a ();
  field_select_pipe_if #(.DATA_W(11), .FIELD_W(3)) bus_b ();

`ifdef FIELD_SELECT_CNT_EN
  logic [15:0] xc_a, xc_b;
  logic [7:0]  ec_a, ec_b;
`endif

  field_select_pipe #(.FIELD_W(3), .NUM_FIELDS(4), .DATA_W(16)) dut_a (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef FIELD_SELECT_CNT_EN
    .o_xfer_cnt (xc_a),
    .o_err_cnt  (ec_a),
`endif
    .bus        (bus_a)
  );

  field_select_pipe #(.FIELD_W(3), .NUM_FIELDS(3), .DATA_W(11)) dut_b (
    .i_clk      (clk),
    .i_rst      (rst),
`ifdef FIELD_SELECT_CNT_EN
    .o_xfer_cnt (xc_b),
    .o_err_cnt  (ec_b),
`endif
    .bus        (bus_b)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned d;
    bit          e;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_a(input logic v, input logic [15:0] d, input logic r);
    bus_a.i_valid = v;
    bus_a.i_data  = d;
    bus_a.i_ready = r;
  endtask

  task automatic set_b(input logic v, input logic [10:0] d, input logic r);
    bus_b.i_valid = v;
    bus_b.i_data  = d;
    bus_b.i_ready = r;
  endtask

  task automatic exp_a(input string tag, input logic v, input logic r,
                       input logic [2:0] d, input logic e);
    chk({tag, "_valid"}, bus_a.o_valid, v);
    chk({tag, "_ready"}, bus_a.o_ready, r);
    if (v) begin
      chk({tag, "_data"}, bus_a.o_data, d);
      chk({tag, "_err"},  bus_a.o_err,  e);
    end
  endtask

  // Reference extraction straight from the word layout: low sel bits, then
  // NUM_FIELDS packed fields of FIELD_W bits.
  function automatic void ref_extract(input int unsigned word, input int nf, input int fw,
                                      output int unsigned d, output bit e);
    int sw;
    int unsigned sel;
    sw  = $clog2(nf);
    sel = word % (1 << sw);
    if (sel < nf) begin
      d = (word / (1 << (sw + sel * fw))) % (1 << fw);
      e = 1'b0;
    end else begin
      d = 0;
      e = 1'b1;
    end
  endfunction

  // Random traffic on one instance; the reference is a FIFO of capacity 2.
  task automatic rand_run(input bit use_b, input int n);
    exp_t        q[$];
    exp_t        tmp;
    bit          hold;
    bit          v, r, acc, xf;
    logic        ov, ordy, oe;
    logic [2:0]  od;
    int unsigned word, d;
    bit          e;
    int          nf;
    hold = 1'b0;
    v    = 1'b0;
    word = 0;
    nf   = use_b ? 3 : 4;
    for (int i = 0; i < n + 4; i++) begin
      ov   = use_b ? bus_b.o_valid : bus_a.o_valid;
      ordy = use_b ? bus_b.o_ready : bus_a.o_ready;
      od   = use_b ? bus_b.o_data  : bus_a.o_data;
      oe   = use_b ? bus_b.o_err   : bus_a.o_err;
      chk("rnd_valid", ov,   q.size() != 0);
      chk("rnd_ready", ordy, q.size() < 2);
      if (q.size() != 0) begin
        chk("rnd_data", od, q[0].d);
        chk("rnd_err",  oe, q[0].e);
      end
      if (i >= n) begin
        // drain phase
        v = 1'b0;
        r = 1'b1;
      end else begin
        if (!hold) begin
          v    = ($urandom_range(0, 3) != 0);
          word = $urandom & (use_b ? 32'h7FF : 32'hFFFF);
        end
        r = ($urandom_range(0, 3) != 0);
      end
      if (use_b) set_b(v, word[10:0], r);
      else       set_a(v, word[15:0], r);
      acc  = v & (q.size() < 2);
      xf   = r & (q.size() != 0);
      hold = v & !(q.size() < 2);
      @(posedge clk);
      if (xf) tmp = q.pop_front();
      if (acc) begin
        ref_extract(word, nf, 3, d, e);
        q.push_back('{d, e});
      end
      @(negedge clk);
    end
    chk("rnd_drained", use_b ? bus_b.o_valid : bus_a.o_valid, 1'b0);
  endtask

  initial begin
    set_a(1'b0, 16'h0, 1'b0);
    set_b(1'b0, 11'h0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state on both instances.
    exp_a("rst", 1'b0, 1'b1, 3'd0, 1'b0);
    chk("rst_data", bus_a.o_data, 3'd0);
    chk("rst_err",  bus_a.o_err,  1'b0);
    chk("rstb_valid", bus_b.o_valid, 1'b0);
    chk("rstb_ready", bus_b.o_ready, 1'b1);

    // Basic extraction: sel=2 -> 3'b101, one cycle latency.
    set_a(1'b1, 16'h0502, 1'b1);
    cycle();
    exp_a("basic", 1'b1, 1'b1, 3'b101, 1'b0);

    // Field 3 then three back-to-back words, no bubble.
    set_a(1'b1, 16'h3FFF, 1'b1);
    cycle();
    exp_a("f3", 1'b1, 1'b1, 3'b111, 1'b0);
    set_a(1'b1, 16'h0001, 1'b1);
    cycle();
    exp_a("b2b1", 1'b1, 1'b1, 3'd0, 1'b0);
    set_a(1'b1, 16'h0002, 1'b1);
    cycle();
    exp_a("b2b2", 1'b1, 1'b1, 3'd0, 1'b0);
    set_a(1'b1, 16'h0003, 1'b1);
    cycle();
    exp_a("b2b3", 1'b1, 1'b1, 3'd0, 1'b0);
    set_a(1'b0, 16'h0, 1'b1);
    cycle();
    exp_a("b2b_idle", 1'b0, 1'b1, 3'd0, 1'b0);

    // Backpressure: words with field0 = 1, 2, 3.
    set_a(1'b1, 16'h0004, 1'b0);
    cycle();
    exp_a("bp1", 1'b1, 1'b1, 3'd1, 1'b0);
    set_a(1'b1, 16'h0008, 1'b0);
    cycle();
    exp_a("bp2", 1'b1, 1'b0, 3'd1, 1'b0);
    set_a(1'b1, 16'h000C, 1'b0);
    cycle();
    exp_a("bp3_held", 1'b1, 1'b0, 3'd1, 1'b0);
    cycle();
    exp_a("bp3_stable", 1'b1, 1'b0, 3'd1, 1'b0);
    set_a(1'b1, 16'h000C, 1'b1);
    cycle();
    exp_a("bp_drain2", 1'b1, 1'b1, 3'd2, 1'b0);
    cycle();
    exp_a("bp_drain3", 1'b1, 1'b1, 3'd3, 1'b0);
    set_a(1'b0, 16'h0, 1'b1);
    cycle();
    exp_a("bp_empty", 1'b0, 1'b1, 3'd0, 1'b0);

    // Out of range on the 3-field instance.
    set_b(1'b1, 11'h7FF, 1'b1);
    cycle();
    chk("oor_valid", bus_b.o_valid, 1'b1);
    chk("oor_data",  bus_b.o_data,  3'd0);
    chk("oor_err",   bus_b.o_err,   1'b1);
    set_b(1'b1, 11'h502, 1'b1);
    cycle();
    chk("sel2_data", bus_b.o_data, 3'b101);
    chk("sel2_err",  bus_b.o_err,  1'b0);
    set_b(1'b0, 11'h0, 1'b1);
    cycle();
    chk("oor_idle", bus_b.o_valid, 1'b0);

    // Reset mid-stream from the two-entry state.
    set_a(1'b1, 16'h0004, 1'b0);
    cycle();
    set_a(1'b1, 16'h0008, 1'b0);
    cycle();
    exp_a("pre_rst", 1'b1, 1'b0, 3'd1, 1'b0);
    set_a(1'b0, 16'h0, 1'b0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    exp_a("mid_rst", 1'b0, 1'b1, 3'd0, 1'b0);
    chk("mid_rst_data", bus_a.o_data, 3'd0);
    chk("mid_rst_err",  bus_a.o_err,  1'b0);
    set_a(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("no_stale", bus_a.o_valid, 1'b0);
    end

    // Random traffic against the reference FIFO.
    rand_run(1'b0, 400);
    rand_run(1'b1, 300);

`ifdef FIELD_SELECT_CNT_EN
    rst = 1'b1;
    set_a(1'b0, 16'h0, 1'b0);
    set_b(1'b0, 11'h0, 1'b0);
    cycle();
    rst = 1'b0;
    chk("cnt_rst_x", xc_a, 16'd0);
    chk("cnt_rst_e", ec_a, 8'd0);
    set_a(1'b1, 16'h0502, 1'b1);
    set_b(1'b1, 11'h7FF, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      if (i == 300) bus_b.i_valid = 1'b0;
      cycle();
    end
    bus_a.i_valid = 1'b0;
    cycle();
    cycle();
    chk("xfer_cnt_wrap", xc_a, 16'd4464);
    chk("err_cnt_a",     ec_a, 8'd0);
    chk("err_cnt_sat",   ec_b, 8'hFF);
    chk("xfer_cnt_b",    xc_b, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
